step_dir_decoder: RTL
=====================

STEP_DIR_DECODER -- requirements
Module: step_dir_decoder

Interface
REQ-001 Parameter POS_W, default 37: width of the signed position accumulator.
REQ-002 Parameter PER_W, default 17: width of the step-period measurement, matching the N period bus width.
REQ-003 Parameter MIN_HIGH, default 2: number of consecutive synchronized-high cycles required to accept a step.
REQ-004 Parameter DIR_SETUP, default 2: number of cycles drv_dir must be stable before an accepted step edge.
REQ-005 Parameter TIMEOUT, default 100000: number of idle cycles after the last accepted step before STALL.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 Port clk, input, 1: the single system clock (50 MHz).
REQ-008 Port rst, input, 1: asynchronous active-low reset.
REQ-009 Port drv_step, input, 1: asynchronous step pulse from the TR/TR_pulse driver chain.
REQ-010 Port drv_dir, input, 1: asynchronous direction input; 1 = increment, 0 = decrement.
REQ-011 Port drv_enable_SM, input, 1: stepper-enable input; low holds the block in DISABLED.
REQ-012 Port pos_load, input, 1: synchronous load strobe for pos_preset.
REQ-013 Port pos_preset, input, POS_W: signed value loaded into position.
REQ-014 Port position, output, POS_W: signed accumulated step count.
REQ-015 Port step_strobe, output, 1: one-cycle pulse for each accepted step.
REQ-016 Port period, output, PER_W: clk cycles between the last two accepted steps.
REQ-017 Port period_valid, output, 1: one-cycle pulse when period updates.
REQ-018 Port dir_err, output, 1: sticky flag for a direction-setup violation.
REQ-019 Port pos_ovf, output, 1: sticky flag for position wrap-around.
REQ-020 Port stalled, output, 1: level output, high while the FSM is in STALL.

Function
REQ-021 drv_step, drv_dir and drv_enable_SM SHALL each pass through a 2-flop synchronizer before any use.
REQ-022 A step SHALL be accepted on the cycle in which synchronized drv_step has been high for exactly MIN_HIGH consecutive cycles; shorter pulses are ignored, and a held-high level produces one step only.
REQ-023 step_strobe SHALL assert 2+MIN_HIGH cycles after the first clk edge at which raw drv_step is high; position updates in the same cycle.
REQ-024 Direction SHALL be the synchronized drv_dir value at acceptance; if drv_dir changed within the last DIR_SETUP cycles, the step still counts with the sampled value and dir_err sets.
REQ-025 position SHALL be updated as position +1 or -1 with two's-complement wrap; a wrap from max to min or from min to max sets pos_ovf.
REQ-026 pos_load SHALL have priority over a simultaneous accepted step: position = pos_preset, the step is dropped, step_strobe still pulses, and pos_load also clears pos_ovf and dir_err.
REQ-027 An interval counter SHALL count cycles since the last accepted step and saturate at 2^PER_W-1.
REQ-028 On each accepted step in RUN, period SHALL take the counter value, period_valid SHALL pulse, and the counter SHALL restart at 1.
REQ-029 The first step after IDLE or STALL SHALL not update period.
REQ-030 FSM states SHALL be DISABLED, IDLE, RUN and STALL.
REQ-031 FSM transitions: any state -> DISABLED when synchronized enable=0; DISABLED -> IDLE when enable=1; IDLE -> RUN on an accepted step; RUN -> STALL when the counter reaches TIMEOUT; STALL -> RUN on an accepted step.
REQ-032 In DISABLED, steps SHALL be ignored; position, flags and period hold; the counter clears.

Reset
REQ-033 While rst=0: FSM=DISABLED, position=0, period=0, all strobes=0, dir_err=0, pos_ovf=0, stalled=0, and synchronizers and filter cleared.
REQ-034 Reset deassertion mid-pulse SHALL not produce a step unless MIN_HIGH full synchronized-high cycles follow.

Structure
REQ-035 FSM state encoding and default parameter constants SHALL reside in shared package tr_pkg.
REQ-036 The synchronizer-plus-filter SHALL be sub-module step_filter, instantiated for drv_step; drv_dir and drv_enable_SM use plain 2-flop synchronizers.

Verification
REQ-037 10 step pulses of 3-cycle width with dir=1, period 5 cycles -> position=10; period=5 after step 2; 9 period_valid pulses.
REQ-038 1-cycle glitch on drv_step -> no step_strobe; position unchanged.
REQ-039 pos_preset=2^36-1 loaded, one step with dir=1 -> position=-2^36, pos_ovf=1.
REQ-040 dir toggled 1 cycle before a step edge -> step counted with new dir; dir_err=1 until pos_load.
REQ-041 No steps for TIMEOUT cycles in RUN -> stalled=1; next step -> stalled=0, no period_valid.
REQ-042 rst pulsed low during a step pulse -> all outputs 0; drv_enable_SM=0 then steps -> position held.

Source files
------------

// File: rtl/tr_pkg.sv
// Shared definitions for the step/direction decoder.
//   tr_state_e    : decoder FSM state encoding
//   *_DEF         : default parameter values used by the decoder modules
package tr_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RUN      = 2'd2,
    ST_STALL    = 2'd3
  } tr_state_e;

  localparam int POS_W_DEF     = 37;
  localparam int PER_W_DEF     = 17;
  localparam int MIN_HIGH_DEF  = 2;
  localparam int DIR_SETUP_DEF = 2;
  localparam int TIMEOUT_DEF   = 100000;

endpackage

// File: rtl/step_filter.sv
// Two-flop synchronizer followed by a minimum-high-time filter for the step
// input. Emits a single registered pulse once the synchronized input has been
// high for MIN_HIGH consecutive cycles; a level held high longer gives no
// further pulses until it drops and rises again.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   din   : asynchronous step input
//   pulse : one-cycle pulse per accepted step
module step_filter
  import tr_pkg::*;
#(
  parameter int MIN_HIGH = MIN_HIGH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  localparam int              CNT_W   = $clog2(MIN_HIGH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(MIN_HIGH - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] high_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      high_cnt <= '0;
      pulse    <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (!sync2) begin
        high_cnt <= '0;
      end else if (high_cnt != CNT_MAX) begin
        // Saturating at MIN_HIGH is what makes a held level count once.
        high_cnt <= high_cnt + CNT_W'(1);
        if (high_cnt == CNT_HIT) pulse <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_dir_decoder.sv
// Step/direction decoder: turns an asynchronous step/dir pair into a signed
// position count, measures the step period and flags timing problems.
//   clk           : system clock
//   rst           : asynchronous active-low reset
//   drv_step      : asynchronous step pulse
//   drv_dir       : asynchronous direction (1 = up, 0 = down)
//   drv_enable_SM : asynchronous enable; low forces DISABLED
//   pos_load      : load pos_preset into position (wins over a step)
//   pos_preset    : signed load value
//   position      : signed step count, two's-complement wrap
//   step_strobe   : one-cycle pulse per accepted step
//   period        : clk cycles between the last two accepted steps
//   period_valid  : one-cycle pulse when period updates
//   dir_err       : sticky, direction changed too close to a step
//   pos_ovf       : sticky, position wrapped
//   stalled       : high while in STALL
//
// state       | meaning
// ST_DISABLED | enable low; steps ignored, outputs held, interval cleared
// ST_IDLE     | enabled, no step seen yet
// ST_RUN      | stepping; each step updates period
// ST_STALL    | no step for TIMEOUT cycles; next step resumes RUN silently
module step_dir_decoder
  import tr_pkg::*;
#(
  parameter int POS_W     = POS_W_DEF,
  parameter int PER_W     = PER_W_DEF,
  parameter int MIN_HIGH  = MIN_HIGH_DEF,
  parameter int DIR_SETUP = DIR_SETUP_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_step,
  input  logic                    drv_dir,
  input  logic                    drv_enable_SM,
  input  logic                    pos_load,
  input  logic signed [POS_W-1:0] pos_preset,
  output logic signed [POS_W-1:0] position,
  output logic                    step_strobe,
  output logic        [PER_W-1:0] period,
  output logic                    period_valid,
  output logic                    dir_err,
  output logic                    pos_ovf,
  output logic                    stalled
);

  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  // A TIMEOUT beyond the counter range is clamped so the saturated counter
  // still reaches it.
  localparam logic [PER_W-1:0] TIMEOUT_CNT =
    (TIMEOUT >= 2**PER_W) ? {PER_W{1'b1}} : PER_W'(TIMEOUT);

  // The filter pulse comes MIN_HIGH cycles after the synchronized step rose,
  // so requiring DIR_SETUP + MIN_HIGH cycles of stable dir at acceptance means
  // dir was stable DIR_SETUP cycles before the synchronized step edge and
  // did not move while the step was being qualified.
  localparam int              AGE_MAX = DIR_SETUP + MIN_HIGH;
  localparam int              AGE_W   = $clog2(AGE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

  tr_state_e        state;
  logic             step_pulse;
  logic             step_acc;
  logic             dir_s1, dir_s2;
  logic             en_s1, en_s2;
  logic [AGE_W-1:0] dir_age;
  logic [PER_W-1:0] interval;
  logic [PER_W-1:0] interval_inc;

  step_filter #(.MIN_HIGH(MIN_HIGH)) u_step_filter (
    .clk   (clk),
    .rst   (rst),
    .din   (drv_step),
    .pulse (step_pulse)
  );

  assign step_acc     = step_pulse && en_s2 && (state != ST_DISABLED);
  assign interval_inc = (interval == {PER_W{1'b1}}) ? interval : interval + PER_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_s1       <= 1'b0;
      dir_s2       <= 1'b0;
      en_s1        <= 1'b0;
      en_s2        <= 1'b0;
      dir_age      <= AGE_LIM;  // no dir history after reset: treat as settled
      state        <= ST_DISABLED;
      interval     <= '0;
      position     <= '0;
      period       <= '0;
      step_strobe  <= 1'b0;
      period_valid <= 1'b0;
      dir_err      <= 1'b0;
      pos_ovf      <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      dir_s1 <= drv_dir;
      dir_s2 <= dir_s1;
      en_s1  <= drv_enable_SM;
      en_s2  <= en_s1;

      if (dir_s1 != dir_s2)      dir_age <= '0;
      else if (dir_age != AGE_LIM) dir_age <= dir_age + AGE_W'(1);

      step_strobe  <= step_acc;
      period_valid <= 1'b0;

      if (!en_s2) begin
        state    <= ST_DISABLED;
        interval <= '0;
        stalled  <= 1'b0;
      end else begin
        case (state)
          ST_DISABLED: begin
            state    <= ST_IDLE;
            interval <= '0;
          end
          ST_IDLE: begin
            if (step_acc) begin
              state    <= ST_RUN;
              interval <= PER_W'(1);
            end
          end
          ST_RUN: begin
            if (step_acc) begin
              period       <= interval;
              period_valid <= 1'b1;
              interval     <= PER_W'(1);
            end else if (interval == TIMEOUT_CNT) begin
              state    <= ST_STALL;
              stalled  <= 1'b1;
              interval <= interval_inc;
            end else begin
              interval <= interval_inc;
            end
          end
          ST_STALL: begin
            if (step_acc) begin
              state    <= ST_RUN;
              stalled  <= 1'b0;
              interval <= PER_W'(1);
            end else begin
              interval <= interval_inc;
            end
          end
          default: state <= ST_DISABLED;
        endcase
      end

      if (pos_load) begin
        position <= pos_preset;
        pos_ovf  <= 1'b0;
        dir_err  <= 1'b0;
      end else if (step_acc) begin
        if (dir_s2) begin
          position <= position + POS_W'(1);
          if (position == POS_MAX) pos_ovf <= 1'b1;
        end else begin
          position <= position - POS_W'(1);
          if (position == POS_MIN) pos_ovf <= 1'b1;
        end
        if (dir_age != AGE_LIM) dir_err <= 1'b1;
      end
    end
  end

endmodule
